sample_scheduler: RTL and testbench

//  Sequences AD7276 conversions at the rate set by the sampling_time period
//  (period_in, in clk cycles). Issues one conv_req per period, handshakes with
//  the SPI capture engine via conv_done, and counts samples into frames of

---
 rtl/sample_scheduler_if.sv | 24 ++
 rtl/sample_scheduler.sv | 91 +++++++++
 tb/tb_sample_scheduler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sample_scheduler_if.sv
// sample_scheduler_if: control, handshake and status bus of the conversion sequencer
interface sample_scheduler_if #(parameter int IDX_W = 16);
    logic             enable;
    logic [31:0]      period_in;
    logic             clear_flags;
    logic             conv_done;
    logic             conv_req;
    logic [IDX_W-1:0] sample_idx;
    logic             sample_last;
    logic             frame_done;
    logic             frame_abort;
    logic [31:0]      period_act;
    logic             busy;
    logic             overrun;
    logic             timeout;
    modport master (
        output enable, period_in, clear_flags, conv_done,
        input  conv_req, sample_idx, sample_last, frame_done, frame_abort, period_act, busy, overrun, timeout
    );
    modport slave (
        input  enable, period_in, clear_flags, conv_done,
        output conv_req, sample_idx, sample_last, frame_done, frame_abort, period_act, busy, overrun, timeout
    );
endinterface

// File: rtl/sample_scheduler.sv
// sample_scheduler: paces AD7276 conversions at a fixed period and counts them into frames
module sample_scheduler #(
    parameter int FRAME_LEN    = 1024,
    parameter int IDX_W        = 16,
    parameter int CONV_TIMEOUT = 64
) (
    input logic               clk,
    input logic               rst,
    sample_scheduler_if.slave bus
);
    localparam int TO_W = $clog2(CONV_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(CONV_TIMEOUT - 1);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, BUSY} state_t;
    state_t state_q, state_d;
    logic [31:0] period_q, period_d, cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TO_W-1:0] to_q, to_d;
    logic pend_q, pend_d, ovr_q, ovr_d, tmo_q, tmo_d;
    logic running, tick, req, expire, done_evt, abort_evt;
    assign running = state_q == WAIT || state_q == BUSY;
    assign tick = running && cnt_q == period_q - 32'd1;
    assign bus.conv_req = req;
    assign bus.sample_idx = idx_q;
    assign bus.sample_last = idx_q == LAST;
    assign bus.frame_done = done_evt;
    assign bus.frame_abort = abort_evt;
    assign bus.period_act = period_q;
    assign bus.busy = state_q != IDLE;
    assign bus.overrun = ovr_q;
    assign bus.timeout = tmo_q;
    // Register all state; reset drops straight to IDLE without any frame event
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            period_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            to_q     <= '0;
            pend_q   <= 1'b0;
            ovr_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            to_q     <= to_d;
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
            tmo_q    <= tmo_d;
        end
    end
    // Next state, free-running period counter, conversion watchdog and sticky flags
    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        idx_d     = idx_q;
        pend_d    = 1'b0;
        done_evt  = 1'b0;
        abort_evt = 1'b0;
        req       = state_q == WAIT && bus.enable && (tick || pend_q);
        expire    = state_q == BUSY && !bus.conv_done && to_q == TO_LAST;
        cnt_d     = state_q == LOAD ? '0 : running ? (tick ? '0 : cnt_q + 32'd1) : cnt_q;
        to_d      = req ? TO_W'(1) : state_q == BUSY ? to_q + TO_W'(1) : to_q;
        ovr_d     = !bus.clear_flags && (ovr_q || (state_q == BUSY && tick && !bus.conv_done));
        tmo_d     = !bus.clear_flags && (tmo_q || expire);
        case (state_q)
            IDLE: state_d = bus.enable ? LOAD : IDLE;
            LOAD: begin
                state_d  = WAIT;
                period_d = bus.period_in == '0 ? 32'd1 : bus.period_in;
                idx_d    = '0;
            end
            WAIT: begin
                abort_evt = !bus.enable;
                state_d   = !bus.enable ? IDLE : req ? BUSY : WAIT;
            end
            BUSY: if (bus.conv_done) begin
                pend_d    = tick;
                done_evt  = idx_q == LAST;
                idx_d     = done_evt ? idx_q : idx_q + IDX_W'(1);
                abort_evt = !done_evt && !bus.enable;
                state_d   = !bus.enable ? IDLE : done_evt ? LOAD : WAIT;
            end else if (expire) begin
                abort_evt = !bus.enable;
                state_d   = bus.enable ? WAIT : IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_sample_scheduler.sv
// tb_sample_scheduler: directed checks of pacing, framing, flags and abort paths
module tb_sample_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0, total = 0, bad = 0;
    int dly = 0, due = -1, n_fd = 0, n_fa = 0, ovr_at = -1, tmo_at = -1, c0 = 0;
    int reqs[$];
    sample_scheduler_if #(.IDX_W(16)) bus();
    sample_scheduler #(.FRAME_LEN(4), .IDX_W(16), .CONV_TIMEOUT(64)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // SPI engine model: answers each conv_req dly cycles later (dly=0 never answers) and logs events
    initial begin
        bus.conv_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.conv_done = dly != 0 && cyc == due;
            #1;
            if (bus.conv_req) begin
                reqs.push_back(cyc);
                due = cyc + dly;
            end
            if (bus.frame_done) n_fd++;
            if (bus.frame_abort) n_fa++;
            if (bus.overrun && ovr_at < 0) ovr_at = cyc;
            if (bus.timeout && tmo_at < 0) tmo_at = cyc;
        end
    end
    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic run_until(input int n, input int budget);
        int b = 0;
        while (reqs.size() < n && b < budget) begin
            step();
            b++;
        end
        check("req_wait", reqs.size(), n);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.clear_flags = 1'b0;
        dly = 0;
        step(2);
        reqs.delete();
        n_fd = 0;
        n_fa = 0;
        ovr_at = -1;
        tmo_at = -1;
        rst = 1'b0;
        step();
    endtask
    task automatic start(input int p, input int d);
        bus.period_in = p;
        dly = d;
        bus.enable = 1'b1;
        c0 = cyc;
    endtask
    initial begin
        bus.enable = 1'b0;
        bus.period_in = 0;
        bus.clear_flags = 1'b0;
        step(3);
        check("rst_busy", bus.busy, 0);
        check("rst_req", bus.conv_req, 0);
        check("rst_period", bus.period_act, 0);
        check("rst_idx", bus.sample_idx, 0);
        check("rst_flags", {bus.overrun, bus.timeout}, 0);
        do_reset();
        start(100, 10);
        run_until(1, 300);
        check("t1_latency", reqs[0] - c0, 101);
        run_until(4, 600);
        check("t1_idx3", bus.sample_idx, 3);
        check("t1_last", bus.sample_last, 1);
        run_until(5, 600);
        check("t1_sp1", reqs[1] - reqs[0], 100);
        check("t1_sp2", reqs[2] - reqs[1], 100);
        check("t1_sp3", reqs[3] - reqs[2], 100);
        check("t1_gap", reqs[4] - reqs[3], 111);
        check("t1_fdone", n_fd, 1);
        check("t1_idx0", bus.sample_idx, 0);
        check("t1_flags", {bus.overrun, bus.timeout}, 0);
        check("t1_period", bus.period_act, 100);
        do_reset();
        start(0, 1);
        run_until(5, 100);
        check("t2_period", bus.period_act, 1);
        check("t2_latency", reqs[0] - c0, 2);
        check("t2_sp", reqs[1] - reqs[0], 2);
        check("t2_gap", reqs[4] - reqs[3], 3);
        check("t2_fdone", n_fd, 1);
        check("t2_overrun", bus.overrun, 0);
        do_reset();
        start(20, 30);
        run_until(2, 200);
        check("t3_ovr_at", ovr_at - reqs[0], 21);
        check("t3_sp", reqs[1] - reqs[0], 40);
        bus.clear_flags = 1'b1;
        step();
        bus.clear_flags = 1'b0;
        check("t3_cleared", bus.overrun, 0);
        check("t3_timeout", bus.timeout, 0);
        do_reset();
        start(100, 0);
        run_until(2, 400);
        check("t4_tmo_at", tmo_at - reqs[0], 64);
        check("t4_sp", reqs[1] - reqs[0], 100);
        check("t4_idx", bus.sample_idx, 0);
        check("t4_overrun", bus.overrun, 0);
        do_reset();
        start(200, 10);
        run_until(1, 400);
        bus.period_in = 400;
        run_until(2, 400);
        check("t5_period_old", bus.period_act, 200);
        run_until(6, 2000);
        check("t5_sp1", reqs[1] - reqs[0], 200);
        check("t5_sp3", reqs[3] - reqs[2], 200);
        check("t5_gap", reqs[4] - reqs[3], 411);
        check("t5_sp_new", reqs[5] - reqs[4], 400);
        check("t5_period_new", bus.period_act, 400);
        do_reset();
        start(30, 50);
        step(10);
        bus.enable = 1'b0;
        #1;
        check("t6_abort", bus.frame_abort, 1);
        step();
        check("t6_idle", bus.busy, 0);
        check("t6_noreq", reqs.size(), 0);
        start(30, 50);
        run_until(1, 100);
        step(2);
        check("t6_inbusy", bus.busy, 1);
        rst = 1'b1;
        step();
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_req", bus.conv_req, 0);
        check("t6_rst_idx", bus.sample_idx, 0);
        check("t6_rst_period", bus.period_act, 0);
        check("t6_rst_abort", bus.frame_abort, 0);
        rst = 1'b0;
        bus.enable = 1'b0;
        step(60);
        check("t6_after_busy", bus.busy, 0);
        check("t6_after_reqs", reqs.size(), 1);
        check("t6_after_idx", bus.sample_idx, 0);
        check("t6_no_events", n_fd + n_fa, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
